// File: rtl/prim_pack.sv
// Narrow-to-wide packer: gathers up to RATIO upstream beats into one registered output word.
// The output register doubles as the packing buffer, so a partial word is built in place.
module prim_pack #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  output logic                          urdy_o,
  input  logic                          uvld_i,
  input  logic [IN_WIDTH-1:0]           udat_i,
  input  logic                          ulast_i,
  input  logic                          drdy_i,
  output logic                          dvld_o,
  output logic [RATIO*IN_WIDTH-1:0]     ddat_o,
  output logic                          dlast_o,
  output logic [$clog2(RATIO+1)-1:0]    dcnt_o
);

  localparam int unsigned CntW  = $clog2(RATIO);
  localparam int unsigned DcntW = $clog2(RATIO + 1);

  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      dvld_q, dvld_d;
  logic [RATIO*IN_WIDTH-1:0] dat_q, dat_d;
  logic                      last_q, last_d;
  logic [DcntW-1:0]          dcnt_q, dcnt_d;

  logic            ubeat;
  logic            dbeat;
  logic            closes;
  logic [CntW-1:0] lane;

  // Ready stays low during reset so nothing is accepted before the packer is live.
  assign urdy_o = reset_n & (~dvld_q | drdy_i);
  assign ubeat  = uvld_i & urdy_o;
  assign dbeat  = dvld_q & drdy_i;
  assign closes = (cnt_q == CntW'(RATIO - 1)) | ulast_i;
  assign lane   = MSB_FIRST ? (CntW'(RATIO - 1) - cnt_q) : cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    dvld_d = dvld_q;
    dat_d  = dat_q;
    last_d = last_q;
    dcnt_d = dcnt_q;

    if (dbeat) begin
      dvld_d = 1'b0;
    end

    if (ubeat) begin
      // A new word clears stale lanes so partial words read zero in unfilled lanes.
      if (cnt_q == '0) begin
        dat_d = '0;
      end
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (CntW'(i) == lane) begin
          dat_d[i*IN_WIDTH +: IN_WIDTH] = udat_i;
        end
      end
      if (closes) begin
        dvld_d = 1'b1;
        dcnt_d = DcntW'(cnt_q) + DcntW'(1);
        last_d = ulast_i;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      dvld_q <= 1'b0;
      dat_q  <= '0;
      last_q <= 1'b0;
      dcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dvld_q <= dvld_d;
      dat_q  <= dat_d;
      last_q <= last_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign dvld_o  = dvld_q;
  assign ddat_o  = dat_q;
  assign dlast_o = last_q;
  assign dcnt_o  = dcnt_q;

  a_dcnt_range: assert property (@(posedge clk) disable iff (!reset_n)
    dvld_q |-> (dcnt_q >= DcntW'(1) && dcnt_q <= DcntW'(RATIO)));

endmodule

// File: tb/tb_prim_pack.sv
// Bench for prim_pack: two instances (LSB-first and MSB-first) driven in lockstep.
module tb_prim_pack;

  localparam int unsigned W = 8;
  localparam int unsigned R = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         uvld = 1'b0;
  logic [W-1:0] udat = '0;
  logic         ulast = 1'b0;
  logic         drdy = 1'b0;

  logic           urdy0, dvld0, dlast0;
  logic [R*W-1:0] ddat0;
  logic [2:0]     dcnt0;
  logic           urdy1, dvld1, dlast1;
  logic [R*W-1:0] ddat1;
  logic [2:0]     dcnt1;

  prim_pack #(.IN_WIDTH(W), .RATIO(R), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .urdy_o(urdy0), .uvld_i(uvld), .udat_i(udat),
    .ulast_i(ulast), .drdy_i(drdy), .dvld_o(dvld0), .ddat_o(ddat0), .dlast_o(dlast0),
    .dcnt_o(dcnt0)
  );

  prim_pack #(.IN_WIDTH(W), .RATIO(R), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .urdy_o(urdy1), .uvld_i(uvld), .udat_i(udat),
    .ulast_i(ulast), .drdy_i(drdy), .dvld_o(dvld1), .ddat_o(ddat1), .dlast_o(dlast1),
    .dcnt_o(dcnt1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic l, input logic rdy);
    uvld = 1'b1; udat = d; ulast = l; drdy = rdy;
    step();
  endtask

  task automatic chk_word(input string nm, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [2:0] c, input logic l);
    chk({nm, ".dvld"}, 64'(dvld0), 64'd1);
    chk({nm, ".dvld_msb"}, 64'(dvld1), 64'd1);
    chk({nm, ".ddat"}, 64'(ddat0), 64'(w0));
    chk({nm, ".ddat_msb"}, 64'(ddat1), 64'(w1));
    chk({nm, ".dcnt"}, 64'(dcnt0), 64'(c));
    chk({nm, ".dlast"}, 64'(dlast0), 64'(l));
  endtask

  typedef struct {
    logic         uvld;
    logic [W-1:0] udat;
    logic         ulast;
    logic         drdy;
    logic         urdy;
    logic         dvld;
    logic         chk_dat;
    logic [31:0]  dat_lsb;
    logic [31:0]  dat_msb;
    logic [2:0]   cnt;
    logic         last;
  } vec_t;

  vec_t tbl[8];

  // Reference model: accepted beats gathered in a queue, word built from lane positions.
  logic [W-1:0] cur[$];
  logic         m_vld;
  logic [31:0]  m_w0, m_w1;
  logic [2:0]   m_cnt;
  logic         m_last;

  function automatic logic [31:0] pack(input logic [W-1:0] q[$], input bit msb);
    logic [31:0] w = '0;
    for (int i = 0; i < q.size(); i++) begin
      int lane = msb ? (R - 1 - i) : i;
      w[lane*W +: W] = q[i];
    end
    return w;
  endfunction

  task automatic do_reset();
    uvld = 1'b0; ulast = 1'b0; drdy = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step();
  endtask

  initial begin
    int k;
    int last_i;

    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44332211, 32'h11223344, 3'd4, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};
    tbl[5] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};
    tbl[6] = '{1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 32'hAABB0000, 3'd2, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};

    // 1. Reset and idle
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst.urdy", 64'(urdy0), 64'd0);
      chk("rst.dvld", 64'(dvld0), 64'd0);
      chk("rst.ddat", 64'(ddat0), 64'd0);
      chk("rst.dcnt", 64'(dcnt0), 64'd0);
      chk("rst.dlast", 64'(dlast0), 64'd0);
    end
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("idle.urdy", 64'(urdy0), 64'd1);
    step();
    chk("idle.dvld", 64'(dvld0), 64'd0);
    chk("idle.ddat", 64'(ddat0), 64'd0);
    chk("idle.dcnt", 64'(dcnt0), 64'd0);

    // 2/3. Full word and early-last word from the table
    for (int i = 0; i < 8; i++) begin
      uvld = tbl[i].uvld; udat = tbl[i].udat; ulast = tbl[i].ulast; drdy = tbl[i].drdy;
      #1;
      chk($sformatf("tbl%0d.urdy", i), 64'(urdy0), 64'(tbl[i].urdy));
      step();
      chk($sformatf("tbl%0d.dvld", i), 64'(dvld0), 64'(tbl[i].dvld));
      chk($sformatf("tbl%0d.dvld_msb", i), 64'(dvld1), 64'(tbl[i].dvld));
      if (tbl[i].chk_dat) begin
        chk($sformatf("tbl%0d.ddat", i), 64'(ddat0), 64'(tbl[i].dat_lsb));
        chk($sformatf("tbl%0d.ddat_msb", i), 64'(ddat1), 64'(tbl[i].dat_msb));
        chk($sformatf("tbl%0d.dcnt", i), 64'(dcnt0), 64'(tbl[i].cnt));
        chk($sformatf("tbl%0d.dlast", i), 64'(dlast0), 64'(tbl[i].last));
      end
    end

    // 4. Backpressure, then consume and accept in the same edge
    for (int i = 1; i <= 4; i++) beat(W'(i), 1'b0, 1'b0);
    chk_word("bp.word", 32'h04030201, 32'h01020304, 3'd4, 1'b0);
    uvld = 1'b1; udat = 8'h05; ulast = 1'b0; drdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp.urdy_hold", 64'(urdy0), 64'd0);
      step();
      chk_word("bp.hold", 32'h04030201, 32'h01020304, 3'd4, 1'b0);
    end
    drdy = 1'b1;
    #1;
    chk("bp.urdy_rel", 64'(urdy0), 64'd1);
    step();
    chk("bp.dvld_fall", 64'(dvld0), 64'd0);
    for (int i = 6; i <= 8; i++) beat(W'(i), 1'b0, 1'b1);
    chk_word("bp.next", 32'h08070605, 32'h05060708, 3'd4, 1'b0);

    // 5. Streaming 32 beats, no bubbles
    k = 0;
    last_i = 0;
    for (int i = 0; i < 32; i++) begin
      beat(W'(i), 1'b0, 1'b1);
      chk($sformatf("stream%0d.dvld", i), 64'(dvld0), 64'((i % 4) == 3));
      if (dvld0) begin
        logic [31:0] e;
        e = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        chk($sformatf("stream.word%0d", k), 64'(ddat0), 64'(e));
        if (k > 0) chk("stream.spacing", 64'(i - last_i), 64'd4);
        last_i = i;
        k++;
      end
    end
    chk("stream.words", 64'(k), 64'd8);
    uvld = 1'b0;
    step();

    // 6. Asynchronous reset mid-word
    beat(8'h11, 1'b0, 1'b1);
    beat(8'h22, 1'b0, 1'b1);
    uvld = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst.dvld", 64'(dvld0), 64'd0);
    chk("arst.ddat", 64'(ddat0), 64'd0);
    chk("arst.urdy", 64'(urdy0), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step();
    beat(8'h55, 1'b0, 1'b1);
    beat(8'h66, 1'b0, 1'b1);
    beat(8'h77, 1'b0, 1'b1);
    chk("arst.nopartial", 64'(dvld0), 64'd0);
    beat(8'h88, 1'b0, 1'b1);
    chk_word("arst.word", 32'h88776655, 32'h55667788, 3'd4, 1'b0);

    // Randomized traffic against the queue model
    do_reset();
    cur.delete();
    m_vld = 1'b0; m_w0 = '0; m_w1 = '0; m_cnt = '0; m_last = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic m_urdy, ub;
      uvld  = ($urandom % 4) != 0;
      udat  = W'($urandom);
      ulast = ($urandom % 5) == 0;
      drdy  = ($urandom % 3) != 0;
      m_urdy = !m_vld || drdy;
      #1;
      chk("rnd.urdy", 64'(urdy0), 64'(m_urdy));
      ub = uvld && m_urdy;
      if (m_vld && drdy) m_vld = 1'b0;
      if (ub) begin
        cur.push_back(udat);
        if (cur.size() == R || ulast) begin
          m_vld  = 1'b1;
          m_w0   = pack(cur, 1'b0);
          m_w1   = pack(cur, 1'b1);
          m_cnt  = 3'(cur.size());
          m_last = ulast;
          cur.delete();
        end
      end
      step();
      chk("rnd.dvld", 64'(dvld0), 64'(m_vld));
      if (m_vld) chk_word("rnd", m_w0, m_w1, m_cnt, m_last);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
